// File: rtl/dec_pkg.sv
// Shared types and helpers for the one-hot decoder/scanner.
// Optional feature macro used by the top: DEC_WRAP_IRQ_EN.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the decode helper supports; N above this is not supported.
    localparam int MAX_N    = 10;
    localparam int MAX_OUTS = 1 << MAX_N;

    function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_N-1:0] k);
        logic [MAX_OUTS-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_nxm_seq_if.sv
// Load/output bundle between a select source and decoder_nxm_seq.
interface decoder_nxm_seq_if #(
    parameter int N = 3
);
    localparam int OUTS = 2 ** N;

    logic            e;
    logic            mode;
    logic [N-1:0]    x;
    logic            x_valid;
    logic            x_ready;
    logic [OUTS-1:0] y;
    logic [N-1:0]    idx;
    logic            busy;

    modport master (
        output e, mode, x, x_valid,
        input  x_ready, y, idx, busy
    );

    modport slave (
        input  e, mode, x, x_valid,
        output x_ready, y, idx, busy
    );

endinterface

// File: rtl/dec_dwell_cnt.sv
// Dwell timer for scan mode: counts enabled cycles, wraps at DWELL-1 and
// flags the terminal count so the caller can advance its index.
module dec_dwell_cnt #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tc = (cnt == TC_VAL);

    // Clear dominates; otherwise count while enabled, wrapping on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_nxm_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready load and scan mode.
// Optional macro DEC_WRAP_IRQ_EN adds a one-cycle wrap_irq output.
//
// state | meaning
// IDLE  | nothing selected, y low, waiting for a load or scan request
// HOLD  | holding the last accepted index on y (gated by e)
// SCAN  | stepping idx every DWELL enabled cycles, load port closed
module decoder_nxm_seq
    import dec_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef DEC_WRAP_IRQ_EN
    output logic                   wrap_irq,
`endif
    decoder_nxm_seq_if.slave       bus
);
    localparam int OUTS = 2 ** N;

    state_t              state;
    state_t              state_n;
    logic [N-1:0]        idx;
    logic [N-1:0]        idx_n;
    logic [OUTS-1:0]     y_q;
    logic                busy_q;
    logic                accept;
    logic                cnt_en;
    logic                cnt_clr;
    logic                cnt_tc;
    logic [MAX_OUTS-1:0] dec_full;

    assign bus.x_ready = (bus.mode == MODE_DIRECT) && (state != SCAN);
    assign accept      = bus.x_valid && bus.x_ready;
    assign bus.y       = y_q;
    assign bus.idx     = idx;
    assign bus.busy    = busy_q;

    // The timer only runs inside SCAN with mode still requesting scan, so
    // every entry into SCAN and every exit leaves it at zero.
    assign cnt_clr = (state != SCAN) || (bus.mode == MODE_DIRECT);
    assign cnt_en  = (state == SCAN) && bus.e;

    dec_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .tc    (cnt_tc)
    );

    // Next state and index; mode=1 beats a pending x_valid.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (bus.mode == MODE_SCAN) begin
                    state_n = SCAN;
                    idx_n   = '0;
                end else if (accept) begin
                    state_n = HOLD;
                    idx_n   = bus.x;
                end
            end
            HOLD: begin
                if (bus.mode == MODE_SCAN) begin
                    state_n = SCAN;
                end else if (accept) begin
                    idx_n = bus.x;
                end
            end
            SCAN: begin
                if (bus.mode == MODE_DIRECT) begin
                    state_n = HOLD;
                end else if (bus.e && cnt_tc) begin
                    idx_n = idx + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    assign dec_full = onehot(MAX_N'(idx_n));

    generate
        if (OUTS < MAX_OUTS) begin : g_unused_dec
            logic unused_dec_hi;
            assign unused_dec_hi = ^dec_full[MAX_OUTS-1:OUTS];
        end
    endgenerate

    // State register plus registered outputs, so y never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            y_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            y_q    <= (bus.e && (state_n != IDLE)) ? dec_full[OUTS-1:0] : '0;
            busy_q <= (state_n == SCAN);
        end
    end

`ifdef DEC_WRAP_IRQ_EN
    // Pulses on the same edge that y moves from the last line back to line 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_irq <= 1'b0;
        end else begin
            wrap_irq <= (state == SCAN) && (bus.mode == MODE_SCAN) && bus.e
                        && cnt_tc && (&idx);
        end
    end
`endif

endmodule

// File: tb/tb_decoder_nxm_seq.sv
// Scoreboard bench for decoder_nxm_seq (N=3, DWELL=4).
module tb_decoder_nxm_seq;

    typedef struct {
        logic [7:0] y;
        logic [2:0] idx;
        logic       busy;
        logic       rdy;
        logic       irq;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
`ifdef DEC_WRAP_IRQ_EN
    logic wrap_irq;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    event chk_ev;

    decoder_nxm_seq_if #(.N(3)) bus ();

    decoder_nxm_seq #(
        .N     (3),
        .DWELL (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef DEC_WRAP_IRQ_EN
        .wrap_irq (wrap_irq),
`endif
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at the falling edge and queue what the outputs must be after the
    // following rising edge. x_ready is combinational on the mode just driven.
    task automatic cyc_step(input logic e, input logic m, input logic [2:0] x,
                            input logic xv, input logic [7:0] ey,
                            input logic [2:0] eidx, input logic ebusy,
                            input logic eirq, input string tag);
        exp_t it;
        @(negedge clk);
        bus.e       = e;
        bus.mode    = m;
        bus.x       = x;
        bus.x_valid = xv;
        it.y    = ey;
        it.idx  = eidx;
        it.busy = ebusy;
        it.rdy  = ~m & ~ebusy;
        it.irq  = eirq;
        it.tag  = tag;
        q.push_back(it);
    endtask

    // Reset pulse between edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        exp_t it;
        @(negedge clk);
        bus.e       = 1'b1;
        bus.mode    = 1'b0;
        bus.x_valid = 1'b0;
        rst_n       = 1'b0;
        it.y    = 8'h00;
        it.idx  = 3'd0;
        it.busy = 1'b0;
        it.rdy  = 1'b1;
        it.irq  = 1'b0;
        it.tag  = tag;
        q.push_back(it);
        ->chk_ev;
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: pop one expectation per observation point and compare.
    initial begin
        exp_t it;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                total++;
                if (bus.y !== it.y || bus.idx !== it.idx || bus.busy !== it.busy
                    || bus.x_ready !== it.rdy) begin
                    bad++;
                    $display("FAIL %s: got y=%h idx=%0d busy=%b rdy=%b, want y=%h idx=%0d busy=%b rdy=%b",
                             it.tag, bus.y, bus.idx, bus.busy, bus.x_ready,
                             it.y, it.idx, it.busy, it.rdy);
                end
`ifdef DEC_WRAP_IRQ_EN
                total++;
                if (wrap_irq !== it.irq) begin
                    bad++;
                    $display("FAIL %s wrap_irq: got %b want %b", it.tag, wrap_irq, it.irq);
                end
`endif
            end
        end
    end

    initial begin
        logic [2:0] si;
        logic [7:0] sy;
        rst_n       = 1'b0;
        bus.e       = 1'b0;
        bus.mode    = 1'b0;
        bus.x       = 3'd0;
        bus.x_valid = 1'b0;
        #12 rst_n = 1'b1;

        cyc_step(1, 0, 3'd0, 0, 8'h00, 3'd0, 0, 0, "reset_state");

        // direct decode, back-to-back accepts
        cyc_step(1, 0, 3'd5, 1, 8'h20, 3'd5, 0, 0, "direct_x5");
        cyc_step(1, 0, 3'd2, 1, 8'h04, 3'd2, 0, 0, "direct_x2");
        cyc_step(1, 0, 3'd5, 1, 8'h20, 3'd5, 0, 0, "direct_x5b");
        cyc_step(1, 0, 3'd7, 0, 8'h20, 3'd5, 0, 0, "no_valid_hold");

        // enable gating in HOLD
        cyc_step(0, 0, 3'd5, 0, 8'h00, 3'd5, 0, 0, "e_low");
        cyc_step(1, 0, 3'd5, 0, 8'h20, 3'd5, 0, 0, "e_high");

        // back to IDLE, then scan with x_valid=1, x=3 pending throughout
        async_reset("reset_from_hold");
        for (int k = 0; k < 46; k++) begin
            si = 3'((k / 4) % 8);
            sy = 8'h01 << si;
            cyc_step(1, 1, 3'd3, 1, sy, si, 1, (k == 32), $sformatf("scan_k%0d", k));
        end

        // idx=3 with one dwell cycle used: freeze for 6 cycles
        for (int k = 0; k < 6; k++)
            cyc_step(0, 1, 3'd3, 1, 8'h00, 3'd3, 1, 0, $sformatf("freeze_%0d", k));
        cyc_step(1, 1, 3'd3, 0, 8'h08, 3'd3, 1, 0, "resume_a");
        cyc_step(1, 1, 3'd3, 0, 8'h08, 3'd3, 1, 0, "resume_b");
        cyc_step(1, 1, 3'd3, 0, 8'h10, 3'd4, 1, 0, "resume_adv");
        cyc_step(1, 0, 3'd3, 0, 8'h10, 3'd4, 0, 0, "exit_to_hold");

        // scan again from HOLD idx=4 up to idx=6, then reset mid-scan
        for (int k = 0; k < 9; k++) begin
            si = 3'(4 + k / 4);
            sy = 8'h01 << si;
            cyc_step(1, 1, 3'd0, 0, sy, si, 1, 0, $sformatf("rescan_k%0d", k));
        end
        async_reset("reset_mid_scan");
        cyc_step(1, 0, 3'd0, 0, 8'h00, 3'd0, 0, 0, "idle_after_reset");

        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
